// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: sink end of the VGA link.
// Recovers pixel coordinates from hsync/vsync edges, checks line/frame
// timing, tracks lock over clean frames and emits a registered pixel stream.
// Optional build macro: VGA_RX_FRAME_SUM_EN adds the 16-bit frame_sum output
// (additive rgb checksum of each frame's active pixels).
// All sampling is qualified by the one-clk pixel strobe p_tick.
module vga_rx_monitor #(
  parameter int HACT        = 640,
  parameter int HFP         = 16,
  parameter int HSW         = 96,
  parameter int HBP         = 48,
  parameter int VACT        = 480,
  parameter int VFP         = 10,
  parameter int VSW         = 2,
  parameter int VBP         = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [2:0]  rgb_out,
  output logic        frame_done,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [7:0]  err_count
`ifdef VGA_RX_FRAME_SUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;
  localparam int GW     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0] C_CNT_MAX = 10'd1023;
  localparam logic [9:0] C_HTOT_M1 = 10'(HTOTAL - 1);
  localparam logic [9:0] C_HSW_M1  = 10'(HSW - 1);
  localparam logic [9:0] C_VTOT_M1 = 10'(VTOTAL - 1);
  localparam logic [9:0] C_VSW     = 10'(VSW);
  localparam logic [9:0] C_HSTART  = 10'(HSW + HBP);
  localparam logic [9:0] C_HEND    = 10'(HSW + HBP + HACT - 1);
  localparam logic [9:0] C_VSTART  = 10'(VSW + VBP);
  localparam logic [9:0] C_VEND    = 10'(VSW + VBP + VACT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_good;
  logic [GW-1:0] w_good_nxt;
  logic [GW-1:0] w_good_inc;

  // Previous sampled sync levels, stored as "asserted" flags so the
  // polarity is folded in once at the input.
  logic       r_hs_act;
  logic       r_vs_act;
  // Set after the first assertion edge since reset; until then the prior
  // counter value is meaningless and the length checks are skipped.
  logic       r_h_seen;
  logic       r_v_seen;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  logic       r_pixel_valid;
  logic [9:0] r_pixel_x;
  logic [9:0] r_pixel_y;
  logic [2:0] r_rgb_out;
  logic       r_frame_done;
  logic       r_locked;
  logic       r_err_h;
  logic       r_err_v;
  logic [7:0] r_err_count;

  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_h_rise;
  logic       w_h_fall;
  logic       w_v_rise;
  logic       w_v_fall;
  logic [9:0] w_h_cnt_nxt;
  logic [9:0] w_v_cnt_nxt;
  logic       w_err_h;
  logic       w_err_v;
  logic       w_err;
  logic       w_in_win;
  logic       w_frame_done;
  logic       w_lock_nxt;

  assign w_hs_act = (hsync == SYNC_POL);
  assign w_vs_act = (vsync == SYNC_POL);
  assign w_h_rise = p_tick & w_hs_act & ~r_hs_act;
  assign w_h_fall = p_tick & ~w_hs_act & r_hs_act;
  assign w_v_rise = p_tick & w_vs_act & ~r_vs_act;
  assign w_v_fall = p_tick & ~w_vs_act & r_vs_act;
  assign w_err    = w_err_h | w_err_v;
  assign w_good_inc = r_good + GW'(1);
  assign w_lock_nxt = (w_state_nxt == ST_LOCKED);

  // Position of the pixel sampled on this strobe (vsync edge wins over hsync)
  always_comb begin
    w_h_cnt_nxt = r_h_cnt;
    w_v_cnt_nxt = r_v_cnt;
    if (w_h_rise) begin
      w_h_cnt_nxt = 10'd0;
    end else if (p_tick && (r_h_cnt != C_CNT_MAX)) begin
      w_h_cnt_nxt = r_h_cnt + 10'd1;
    end else begin
      w_h_cnt_nxt = r_h_cnt;
    end
    if (w_v_rise) begin
      w_v_cnt_nxt = 10'd0;
    end else if (w_h_rise && (r_v_cnt != C_CNT_MAX)) begin
      w_v_cnt_nxt = r_v_cnt + 10'd1;
    end else begin
      w_v_cnt_nxt = r_v_cnt;
    end
  end

  // Line/frame length and sync pulse width checks on sync edges
  always_comb begin
    w_err_h = 1'b0;
    w_err_v = 1'b0;
    if (w_h_rise && r_h_seen && (r_h_cnt != C_HTOT_M1)) begin
      w_err_h = 1'b1;
    end else if (w_h_fall && (r_h_cnt != C_HSW_M1)) begin
      w_err_h = 1'b1;
    end else begin
      w_err_h = 1'b0;
    end
    if (w_v_rise && r_v_seen && (r_v_cnt != C_VTOT_M1)) begin
      w_err_v = 1'b1;
    end else if (w_v_fall && (w_v_cnt_nxt != C_VSW)) begin
      w_err_v = 1'b1;
    end else begin
      w_err_v = 1'b0;
    end
  end

  assign w_in_win = p_tick &&
                    (w_h_cnt_nxt >= C_HSTART) && (w_h_cnt_nxt <= C_HEND) &&
                    (w_v_cnt_nxt >= C_VSTART) && (w_v_cnt_nxt <= C_VEND);

  // Lock FSM next state; an error always wins over a vsync edge
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good;
    w_frame_done = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_v_rise && !w_err) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
        end else begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      ST_ACQUIRE: begin
        if (w_err) begin
          w_state_nxt = ST_UNLOCKED;
          w_good_nxt  = '0;
        end else if (w_v_rise) begin
          w_good_nxt = w_good_inc;
          if (w_good_inc == GW'(LOCK_FRAMES)) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_ACQUIRE;
          end
        end else begin
          w_state_nxt = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (w_err) begin
          w_state_nxt = ST_UNLOCKED;
          w_good_nxt  = '0;
        end else if (w_v_rise) begin
          w_frame_done = 1'b1;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
        w_good_nxt  = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_UNLOCKED;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Sync sampling and position counters, advanced only on pixel strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hs_act <= 1'b0;
      r_vs_act <= 1'b0;
      r_h_seen <= 1'b0;
      r_v_seen <= 1'b0;
      r_h_cnt  <= 10'd0;
      r_v_cnt  <= 10'd0;
    end else if (p_tick) begin
      r_hs_act <= w_hs_act;
      r_vs_act <= w_vs_act;
      r_h_cnt  <= w_h_cnt_nxt;
      r_v_cnt  <= w_v_cnt_nxt;
      if (w_h_rise) begin
        r_h_seen <= 1'b1;
      end
      if (w_v_rise) begin
        r_v_seen <= 1'b1;
      end
    end
  end

  // Registered status pulses, lock flag and saturating error count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_done <= 1'b0;
      r_locked     <= 1'b0;
      r_err_h      <= 1'b0;
      r_err_v      <= 1'b0;
      r_err_count  <= 8'd0;
    end else begin
      r_frame_done <= w_frame_done;
      r_locked     <= w_lock_nxt;
      r_err_h      <= w_err_h;
      r_err_v      <= w_err_v;
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Pixel stream: valid pulses only while locked; coordinates hold otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pixel_valid <= 1'b0;
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 10'd0;
      r_rgb_out     <= 3'd0;
    end else begin
      r_pixel_valid <= w_in_win & w_lock_nxt;
      if (w_in_win && w_lock_nxt) begin
        r_pixel_x <= w_h_cnt_nxt - C_HSTART;
        r_pixel_y <= w_v_cnt_nxt - C_VSTART;
        r_rgb_out <= rgb;
      end
    end
  end

  assign pixel_valid = r_pixel_valid;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign rgb_out     = r_rgb_out;
  assign frame_done  = r_frame_done;
  assign locked      = r_locked;
  assign err_h       = r_err_h;
  assign err_v       = r_err_v;
  assign err_count   = r_err_count;

`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] r_sum_acc;
  logic [15:0] r_frame_sum;

  // Frame checksum: accumulate active rgb, latch and clear at each vsync edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sum_acc   <= 16'd0;
      r_frame_sum <= 16'd0;
    end else if (w_v_rise) begin
      r_frame_sum <= r_sum_acc;
      r_sum_acc   <= 16'd0;
    end else if (w_in_win) begin
      r_sum_acc <= r_sum_acc + {13'd0, rgb};
    end
  end

  assign frame_sum = r_frame_sum;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized scoreboard bench for vga_rx_monitor on a scaled-down video mode.
// The reference model works on strobe timestamps and line counts.
`timescale 1ns/1ps
module tb_vga_rx_monitor;
  localparam int HACT = 8, HFP = 2, HSW = 3, HBP = 2;
  localparam int VACT = 4, VFP = 1, VSW = 2, VBP = 2;
  localparam bit SYNC_POL = 1'b0;
  localparam int LOCK_FRAMES = 2;
  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;
  localparam int UNL = 0, ACQ = 1, LCK = 2;

  logic clk = 1'b0, reset = 1'b0, p_tick = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1;
  logic [2:0] rgb = 3'd0;
  logic pixel_valid, frame_done, locked, err_h, err_v;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] rgb_out;
  logic [7:0] err_count;
`ifdef VGA_RX_FRAME_SUM_EN
  logic [15:0] frame_sum;
`endif

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .SYNC_POL(SYNC_POL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .rgb_out(rgb_out), .frame_done(frame_done), .locked(locked),
    .err_h(err_h), .err_v(err_v), .err_count(err_count)
`ifdef VGA_RX_FRAME_SUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  typedef struct {
    int cyc; bit valid; int x; int y; int c;
    bit fdone; bit eh; bit ev; bit lk; int ecnt; int fsum;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model state
  int m_t, m_ths, m_lines, m_fsm, m_good, m_errc, m_acc, m_fsum;
  bit m_hprev, m_vprev, m_hseen, m_vseen;

  task automatic chk(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, want %s", name, got, want);
  endtask

  function automatic int sat10(input int n);
    return (n > 1023) ? 1023 : n;
  endfunction

  task automatic model_reset();
    m_t = 0; m_ths = 0; m_lines = 0; m_fsm = UNL; m_good = 0;
    m_errc = 0; m_acc = 0; m_fsum = 0;
    m_hprev = 0; m_vprev = 0; m_hseen = 0; m_vseen = 0;
  endtask

  // One pixel of the link as seen by the spec rules; pushes expected output.
  task automatic model_step(input bit hs, input bit vs, input logic [2:0] c);
    exp_t e;
    bit hrise, hfall, vrise, vfall, eh, ev, err, inwin, fdone;
    int prior_pos, prior_lines, pos;
    m_t++;
    hrise = hs && !m_hprev;  hfall = !hs && m_hprev;
    vrise = vs && !m_vprev;  vfall = !vs && m_vprev;
    prior_pos = sat10(m_t - 1 - m_ths);
    prior_lines = m_lines;
    eh = (hrise && m_hseen && (prior_pos + 1 != HTOTAL)) || (hfall && (prior_pos != HSW - 1));
    if (hrise) begin m_ths = m_t; m_hseen = 1; end
    pos = sat10(m_t - m_ths);
    if (vrise) m_lines = 0;
    else if (hrise && m_lines < 1023) m_lines++;
    ev = (vrise && m_vseen && (prior_lines + 1 != VTOTAL)) || (vfall && (m_lines != VSW));
    if (vrise) m_vseen = 1;
    inwin = (pos >= HSW + HBP) && (pos < HSW + HBP + HACT) &&
            (m_lines >= VSW + VBP) && (m_lines < VSW + VBP + VACT);
    err = eh || ev;
    fdone = 0;
    if (err) m_fsm = UNL;
    else if (vrise) begin
      if (m_fsm == UNL) begin m_fsm = ACQ; m_good = 0; end
      else if (m_fsm == ACQ) begin
        m_good++;
        if (m_good == LOCK_FRAMES) m_fsm = LCK;
      end else fdone = 1;
    end
    if (err && m_errc < 255) m_errc++;
    if (vrise) begin m_fsum = m_acc; m_acc = 0; end
    else if (inwin) m_acc = (m_acc + int'(c)) % 65536;
    m_hprev = hs; m_vprev = vs;
    if (err || fdone || (inwin && m_fsm == LCK)) begin
      e.cyc = cyc + 1; e.valid = inwin && (m_fsm == LCK);
      e.x = pos - (HSW + HBP); e.y = m_lines - (VSW + VBP); e.c = int'(c);
      e.fdone = fdone; e.eh = eh; e.ev = ev; e.lk = (m_fsm == LCK);
      e.ecnt = m_errc; e.fsum = m_fsum;
      exp_q.push_back(e);
    end
  endtask

  task automatic strobe(input bit hs, input bit vs, input logic [2:0] c);
    @(negedge clk);
    p_tick = 1'b1;
    hsync = hs ? SYNC_POL : ~SYNC_POL;
    vsync = vs ? SYNC_POL : ~SYNC_POL;
    rgb = c;
    model_step(hs, vs, c);
    repeat ($urandom_range(1, 2)) begin
      @(negedge clk);
      p_tick = 1'b0;
      rgb = 3'($urandom);
    end
  endtask

  task automatic chk_zero(input string name);
    bit ok;
    ok = !pixel_valid && pixel_x == 10'd0 && pixel_y == 10'd0 && rgb_out == 3'd0 &&
         !frame_done && !locked && !err_h && !err_v && err_count == 8'd0;
`ifdef VGA_RX_FRAME_SUM_EN
    ok = ok && frame_sum == 16'd0;
`endif
    chk(name, ok, $sformatf("v=%0b x=%0d y=%0d rgb=%0d fd=%0b lk=%0b eh=%0b ev=%0b ec=%0d",
        pixel_valid, pixel_x, pixel_y, rgb_out, frame_done, locked, err_h, err_v, err_count),
        "all zero");
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    p_tick = 1'b0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    chk_zero("reset_mid_frame");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_frame(input int vs_lines, input int short_line,
                           input int rst_line, input int rst_px, input bit const_rgb);
    logic [2:0] c;
    for (int l = 0; l < VTOTAL; l++) begin
      for (int p = 0; p < ((l == short_line) ? HTOTAL - 1 : HTOTAL); p++) begin
        c = const_rgb ? 3'b101 : 3'($urandom);
        strobe(p < HSW, l < vs_lines, c);
        if (l == rst_line && p == rst_px) reset_pulse();
      end
    end
  endtask

  task automatic clean_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(VSW, -1, -1, -1, 1'b0);
  endtask

  task automatic chk_status(input string name, input bit lk, input int ec);
    chk(name, (locked == lk) && (int'(err_count) == ec),
        $sformatf("locked=%0b err_count=%0d", locked, err_count),
        $sformatf("locked=%0b err_count=%0d", lk, ec));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor plus per-frame pixel counting
  int  pix_cnt = 0;
  bit  have_ref = 0;
  bit  lk_prev = 0;
  always @(posedge clk) begin
    exp_t e;
    bit ok;
    #2;
    if (locked && !lk_prev) begin pix_cnt = 0; have_ref = 1; end
    if (!locked) have_ref = 0;
    lk_prev = locked;
    if (pixel_valid) pix_cnt++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      ok = (pixel_valid == e.valid) && (frame_done == e.fdone) && (err_h == e.eh) &&
           (err_v == e.ev) && (locked == e.lk) && (int'(err_count) == e.ecnt);
      if (e.valid) ok = ok && int'(pixel_x) == e.x && int'(pixel_y) == e.y && int'(rgb_out) == e.c;
`ifdef VGA_RX_FRAME_SUM_EN
      if (e.fdone) ok = ok && int'(frame_sum) == e.fsum;
`endif
      chk("event", ok,
          $sformatf("cyc%0d v=%0b x=%0d y=%0d c=%0d fd=%0b eh=%0b ev=%0b lk=%0b ec=%0d",
                    cyc, pixel_valid, pixel_x, pixel_y, rgb_out, frame_done, err_h, err_v, locked, err_count),
          $sformatf("v=%0b x=%0d y=%0d c=%0d fd=%0b eh=%0b ev=%0b lk=%0b ec=%0d",
                    e.valid, e.x, e.y, e.c, e.fdone, e.eh, e.ev, e.lk, e.ecnt));
    end else if (pixel_valid || frame_done || err_h || err_v) begin
      chk("unexpected_event", 1'b0,
          $sformatf("cyc%0d v=%0b fd=%0b eh=%0b ev=%0b", cyc, pixel_valid, frame_done, err_h, err_v),
          "no output event");
    end
    if (frame_done) begin
      if (have_ref)
        chk("frame_pixels", pix_cnt == HACT * VACT, $sformatf("%0d", pix_cnt), $sformatf("%0d", HACT * VACT));
      pix_cnt = 0;
      have_ref = 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // clean acquisition: lock at the 3rd vsync edge
    clean_frames(2);
    chk_status("not_locked_after_2_edges", 1'b0, 0);
    clean_frames(1);
    chk_status("locked_after_3_edges", 1'b1, 0);
    run_frame(VSW, -1, -1, -1, 1'b1);
    run_frame(VSW, -1, -1, -1, 1'b1);
    clean_frames(1);

    // one short line while locked
    run_frame(VSW, 5, -1, -1, 1'b0);
    chk_status("short_line_unlock", 1'b0, 1);
    clean_frames(3);
    chk_status("relock_after_short_line", 1'b1, 1);

    // vsync held one line too long
    run_frame(VSW + 1, -1, -1, -1, 1'b0);
    chk_status("long_vsync_unlock", 1'b0, 2);
    clean_frames(3);
    chk_status("relock_after_long_vsync", 1'b1, 2);

    // reset mid-frame at the centre of the active area
    run_frame(VSW, -1, VSW + VBP + VACT / 2, HSW + HBP + HACT / 2, 1'b0);
    chk_status("after_reset_frame", 1'b0, 0);
    clean_frames(2);
    chk_status("not_relocked_yet", 1'b0, 0);
    clean_frames(1);
    chk_status("relock_after_reset", 1'b1, 0);
    clean_frames(1);

    // error counter saturation with a train of short lines
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < HTOTAL - 1; p++) strobe(p < HSW, 1'b0, 3'($urandom));
    end
    chk_status("err_count_saturates", 1'b0, 255);

    repeat (5) @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Sink end of the VGA link: consumes the hsync/vsync/rgb stream produced by the display top level and decodes it.
- Recovers pixel coordinates from the sync edges alone and checks line/frame timing against the 640x480 mode.
- Reports lock and error status, and presents a registered pixel stream for frame capture and self-checking.
- Sits on the same clk as the video generator; samples only on pixel strobes.

Parameters:
HACT, 640, active pixels per line
HFP, 16, horizontal front porch (pixels)
HSW, 96, hsync pulse width (pixels)
HBP, 48, horizontal back porch (pixels)
VACT, 480, active lines per frame
VFP, 10, vertical front porch (lines)
VSW, 2, vsync pulse width (lines)
VBP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
p_tick  in  1  pixel strobe, one clk wide; all sampling qualified by it
hsync  in  1  horizontal sync from link
vsync  in  1  vertical sync from link
rgb  in  3  pixel colour from link
pixel_valid  out  1  registered; high for one clk per active pixel
pixel_x  out  10  active column 0..HACT-1
pixel_y  out  10  active row 0..VACT-1
rgb_out  out  3  rgb sampled with that pixel
frame_done  out  1  one-clk pulse at each vsync assertion edge while LOCKED
locked  out  1  high in LOCKED state
err_h  out  1  one-clk pulse on bad line length or hsync width
err_v  out  1  one-clk pulse on bad frame length or vsync width
err_count  out  8  saturating error count

Behaviour:
- Reset: reset low at a clk edge clears every output to 0, the FSM to UNLOCKED and all counters to 0. Reset overrides everything, including mid-frame operation.
- Sampling:
  - hsync, vsync and rgb are registered on each clk where p_tick=1.
  - Edges are detected against the previous sampled value.
  - The assertion edge is the transition to SYNC_POL.
- Horizontal counter h_cnt (10 bit):
  - Loads 0 on the hsync assertion edge; otherwise increments per p_tick.
  - Saturates at 1023.
- Line length check: at each hsync assertion edge, the prior h_cnt+1 must equal HTOTAL=HACT+HFP+HSW+HBP (800). A mismatch gives err_h, except for the first edge after reset.
- Hsync width check: the deassertion edge must occur at h_cnt==HSW-1; otherwise err_h.
- Vertical counter v_cnt:
  - Loads 0 on the vsync assertion edge.
  - Increments on each hsync assertion edge.
  - When both edges occur on the same strobe, vsync wins: v_cnt=0.
- Frame length check: at the vsync assertion edge, the prior v_cnt+1 must equal VTOTAL (525); otherwise err_v.
- Vsync width check: vsync must deassert at v_cnt==VSW; otherwise err_v.
- Active window: h_cnt in [HSW+HBP, HSW+HBP+HACT-1] and v_cnt in [VSW+VBP, VSW+VBP+VACT-1]. Then pixel_x=h_cnt-(HSW+HBP) and pixel_y=v_cnt-(VSW+VBP).
- Pixel output:
  - pixel_valid, pixel_x, pixel_y and rgb_out update 1 clk after the sampling strobe.
  - Outputs are valid only when locked=1; pixel_valid is forced 0 otherwise.
  - pixel_x and pixel_y hold their last value between strobes.
- FSM:
  - UNLOCKED: on the vsync assertion edge, go to ACQUIRE with good=0.
  - ACQUIRE: at each vsync assertion edge with no error during the frame, good increments. When good reaches LOCK_FRAMES, go to LOCKED. Any err_h or err_v returns to UNLOCKED.
  - LOCKED: frame_done pulses at each vsync assertion edge. Any error goes to UNLOCKED and drops locked in the same clk as the error pulse.
- err_count: increments once per clk in which err_h or err_v is high (both together count as 1). It saturates at 255 and clears only on reset.
- p_tick low: no state changes except registered output pulses returning to 0.

Optional Feature:
- Macro: VGA_RX_FRAME_SUM_EN.
- Defined:
  - Adds output frame_sum (16 bit), an additive sum of zero-extended rgb over all active pixels of a frame.
  - The sum is latched at the vsync assertion edge, updating in the same clk as frame_done; the accumulator then clears.
  - Used by the bench to compare frame images. frame_sum resets to 0.
- Undefined: no port, no logic.

Test Plan:
- Clean 640x480 stream (p_tick every 2nd clk, SYNC_POL=0) -> locked rises at the 3rd vsync assertion edge; err_count=0; exactly 307200 pixel_valid pulses per locked frame.
- Locked, rgb constant 3'b101 -> rgb_out=3'b101 at every pixel; first pixel (0,0) and last (639,479); frame_done once per 525 lines. With VGA_RX_FRAME_SUM_EN: frame_sum=1536000 mod 65536=28672.
- Line shortened to 799 pixels once -> err_h one clk, locked drops same clk, err_count=1, relock after 2 clean frames.
- Vsync held 3 lines -> err_v, err_count increments, FSM to UNLOCKED.
- reset low mid-frame at pixel (320,240) for 1 clk -> all outputs 0 next clk, relock requires 1 arming vsync + 2 clean frames.
- 300 forced errors -> err_count saturates at 255.
